mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/arb_rr2.sv | 39 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for mem_arbiter: FSM states, port ids, timeout default.
// Counter width helper keeps the watchdog at least 9 bits wide.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int TIMEOUT_DEFAULT = 256;
    localparam int CNT_MIN_W       = 9;

    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w > CNT_MIN_W) ? w : CNT_MIN_W;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant selector (instruction vs data) holding the last-granted pointer.
// Macro MEM_ARBITER_RR_EN selects round-robin; otherwise the data port always wins.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic en,
    output logic gnt_vld,
    output logic gnt_port
);

    logic last_q;
    logic last_d;
    logic pick_d;

    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        // On a tie, serve the port that did not win last time.
        pick_d = req_d && (!req_i || (last_q == PORT_I));
`else
        pick_d = req_d;
`endif
        gnt_vld  = en && (req_i || req_d);
        gnt_port = pick_d ? PORT_D : PORT_I;
        last_d   = gnt_vld ? gnt_port : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-refill and a data requester, with a watchdog.
// Optional round-robin between ports via macro MEM_ARBITER_RR_EN (default: data has fixed priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_iread_en,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_inst,
    output logic        o_iread_vd,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_memaddr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_read_vd,
    output logic        o_write_ack,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rvd,
    input  logic        i_mem_wack,
    output logic        o_timeout
);

    localparam int             CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ivd_q, ivd_d;
    logic          rvd_q, rvd_d;
    logic          wack_q, wack_d;
    logic          to_q, to_d;

    logic gnt_vld;
    logic gnt_port;
    logic arb_en;

    // No grant during a response pulse so a still-held request is not re-served at once.
    assign arb_en = (state_q == IDLE) && !(ivd_q || rvd_q || wack_q || to_q);

    arb_rr2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (i_iread_en),
        .req_d    (i_read_en || i_write_en),
        .en       (arb_en),
        .gnt_vld  (gnt_vld),
        .gnt_port (gnt_port)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        inst_d  = inst_q;
        rdata_d = rdata_q;
        ivd_d   = 1'b0;
        rvd_d   = 1'b0;
        wack_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    cnt_d = '0;
                    if (gnt_port == PORT_I) begin
                        addr_d  = i_iaddr;
                        state_d = IREAD;
                    end else begin
                        addr_d = i_memaddr;
                        if (i_write_en) begin
                            wdata_d = i_write_data;
                            state_d = DWRITE;
                        end else begin
                            state_d = DREAD;
                        end
                    end
                end
            end
            IREAD, DREAD: begin
                cnt_d = cnt_q + CW'(1);
                if (i_mem_rvd) begin
                    if (state_q == IREAD) begin
                        inst_d = i_mem_rdata;
                        ivd_d  = 1'b1;
                    end else begin
                        rdata_d = i_mem_rdata;
                        rvd_d   = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            DWRITE: begin
                cnt_d = cnt_q + CW'(1);
                if (i_mem_wack) begin
                    wack_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            inst_q  <= '0;
            rdata_q <= '0;
            ivd_q   <= 1'b0;
            rvd_q   <= 1'b0;
            wack_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            inst_q  <= inst_d;
            rdata_q <= rdata_d;
            ivd_q   <= ivd_d;
            rvd_q   <= rvd_d;
            wack_q  <= wack_d;
            to_q    <= to_d;
        end
    end

    assign o_mem_ren   = (state_q == IREAD) || (state_q == DREAD);
    assign o_mem_wen   = (state_q == DWRITE);
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_inst      = inst_q;
    assign o_read_data = rdata_q;
    assign o_iread_vd  = ivd_q;
    assign o_read_vd   = rvd_q;
    assign o_write_ack = wack_q;
    assign o_timeout   = to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester agents, a memory responder with random
// latency/stray responses/random resets, checked every cycle against a transaction model.
module tb_mem_arbiter;

    localparam int TMO  = 16;
    localparam int NCYC = 6000;

    logic        clk;
    logic        rst;
    logic        i_iread_en;
    logic [31:0] i_iaddr;
    logic [31:0] o_inst;
    logic        o_iread_vd;
    logic        i_read_en;
    logic        i_write_en;
    logic [31:0] i_memaddr;
    logic [31:0] i_write_data;
    logic [31:0] o_read_data;
    logic        o_read_vd;
    logic        o_write_ack;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rvd;
    logic        i_mem_wack;
    logic        o_timeout;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_iread_en   (i_iread_en),
        .i_iaddr      (i_iaddr),
        .o_inst       (o_inst),
        .o_iread_vd   (o_iread_vd),
        .i_read_en    (i_read_en),
        .i_write_en   (i_write_en),
        .i_memaddr    (i_memaddr),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_read_vd    (o_read_vd),
        .o_write_ack  (o_write_ack),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rvd    (i_mem_rvd),
        .i_mem_wack   (i_mem_wack),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one outstanding transaction (port, kind, strobe-cycle age) plus expected outputs.
    logic        m_srv, m_port, m_wr, m_last;
    int          m_age;
    logic [31:0] e_addr, e_wdata, e_inst, e_rdata;
    logic        e_ivd, e_rvd, e_wack, e_to;

    int cov_ivd = 0, cov_rvd = 0, cov_wack = 0, cov_to = 0;

    int r_cnt, r_lat;
    logic r_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic n_ivd, n_rvd, n_wack, n_to, done, want_i, want_d, pick_d;
        if (rst) begin
            m_srv = 0; m_port = 0; m_wr = 0; m_last = 0; m_age = 0;
            e_addr = 0; e_wdata = 0; e_inst = 0; e_rdata = 0;
            e_ivd = 0; e_rvd = 0; e_wack = 0; e_to = 0;
            return;
        end
        n_ivd = 0; n_rvd = 0; n_wack = 0; n_to = 0;
        if (m_srv) begin
            done = m_wr ? i_mem_wack : i_mem_rvd;
            if (done) begin
                m_srv = 0;
                if (m_wr) n_wack = 1;
                else if (m_port) begin n_rvd = 1; e_rdata = i_mem_rdata; end
                else begin n_ivd = 1; e_inst = i_mem_rdata; end
            end else begin
                m_age++;
                if (m_age == TMO - 1) begin m_srv = 0; n_to = 1; end
            end
        end else if (!(e_ivd || e_rvd || e_wack || e_to)) begin
            want_i = i_iread_en;
            want_d = i_read_en || i_write_en;
            if (want_i || want_d) begin
`ifdef MEM_ARBITER_RR_EN
                pick_d = want_d && (!want_i || !m_last);
`else
                pick_d = want_d;
`endif
                m_srv  = 1;
                m_port = pick_d;
                m_last = pick_d;
                m_age  = 0;
                m_wr   = pick_d && i_write_en;
                e_addr = pick_d ? i_memaddr : i_iaddr;
                if (m_wr) e_wdata = i_write_data;
            end
        end
        e_ivd = n_ivd; e_rvd = n_rvd; e_wack = n_wack; e_to = n_to;
    endtask

    task automatic check_outputs();
        chk("mem_ren",   32'(o_mem_ren),   32'(m_srv && !m_wr));
        chk("mem_wen",   32'(o_mem_wen),   32'(m_srv && m_wr));
        chk("excl",      32'(o_mem_ren && o_mem_wen), 32'(0));
        chk("mem_addr",  o_mem_addr,  e_addr);
        chk("mem_wdata", o_mem_wdata, e_wdata);
        chk("inst",      o_inst,      e_inst);
        chk("read_data", o_read_data, e_rdata);
        chk("iread_vd",  32'(o_iread_vd),  32'(e_ivd));
        chk("read_vd",   32'(o_read_vd),   32'(e_rvd));
        chk("write_ack", 32'(o_write_ack), 32'(e_wack));
        chk("timeout",   32'(o_timeout),   32'(e_to));
        if (e_ivd)  cov_ivd++;
        if (e_rvd)  cov_rvd++;
        if (e_wack) cov_wack++;
        if (e_to)   cov_to++;
    endtask

    task automatic drive_agents();
        if (i_iread_en && (e_ivd || (e_to && !m_port)))
            i_iread_en = 0;
        else if (i_iread_en && m_srv && !m_port && $urandom_range(0, 23) == 0)
            i_iread_en = 0;
        else if (!i_iread_en && $urandom_range(0, 2) == 0) begin
            i_iread_en = 1;
            i_iaddr    = $urandom;
        end

        if (i_write_en && (e_wack || (e_to && m_port && m_wr))) i_write_en = 0;
        if (i_read_en && (e_rvd || (e_to && m_port && !m_wr)))  i_read_en = 0;
        if ((i_read_en || i_write_en) && m_srv && m_port && $urandom_range(0, 23) == 0) begin
            i_read_en  = 0;
            i_write_en = 0;
        end else if (!i_read_en && !i_write_en && $urandom_range(0, 2) == 0) begin
            int k;
            k = int'($urandom_range(0, 2));
            i_read_en    = (k != 1);
            i_write_en   = (k != 0);
            i_memaddr    = $urandom;
            i_write_data = $urandom;
        end
    endtask

    task automatic drive_memory();
        i_mem_rvd   = 0;
        i_mem_wack  = 0;
        i_mem_rdata = $urandom;
        if (o_mem_ren || o_mem_wen) begin
            if (!r_busy) begin
                r_busy = 1;
                r_cnt  = 0;
                r_lat  = ($urandom_range(0, 11) == 0) ? 1000 : int'($urandom_range(1, 4));
            end
            r_cnt++;
            if (r_cnt >= r_lat) begin
                if (o_mem_ren) i_mem_rvd = 1;
                else           i_mem_wack = 1;
            end
            if (o_mem_ren && $urandom_range(0, 7) == 0) i_mem_wack = 1;
            if (o_mem_wen && $urandom_range(0, 7) == 0) i_mem_rvd = 1;
        end else begin
            r_busy     = 0;
            i_mem_rvd  = ($urandom_range(0, 5) == 0);
            i_mem_wack = ($urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        rst = 1; i_iread_en = 0; i_iaddr = 0; i_read_en = 0; i_write_en = 0;
        i_memaddr = 0; i_write_data = 0; i_mem_rdata = 0; i_mem_rvd = 0; i_mem_wack = 0;
        r_busy = 0; r_cnt = 0; r_lat = 1;
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs();
            drive_agents();
            drive_memory();
            rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
            model_step();
        end
        chk("cov_iread_vd",  32'(cov_ivd  > 0), 32'(1));
        chk("cov_read_vd",   32'(cov_rvd  > 0), 32'(1));
        chk("cov_write_ack", 32'(cov_wack > 0), 32'(1));
        chk("cov_timeout",   32'(cov_to   > 0), 32'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
